// File: rtl/plab4_net_router_domain_sched.sv
// Time-slot scheduler for a router shared between security domains.
// Each domain owns the router for a fixed slot of p_slot_len cycles. The last
// p_dead_len cycles of every slot are a dead window in which no new flits may
// be injected, so the current domain's traffic can drain before the next
// domain takes over. Slot length never depends on traffic.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-low reset
//   en          - scheduler enable, honoured only at slot boundaries
//   drain_busy  - current domain still has flits in flight
//   clr_err     - clears leak_err (a simultaneous set wins)
//   cur_sd      - domain owning the router this cycle
//   issue_ok    - injection permitted for cur_sd (high only in ACTIVE)
//   slot_cnt    - cycle index within the current slot
//   epoch_start - pulse on the first cycle of domain 0's slot
//   leak_err    - sticky flag: a slot ended while drain_busy was high
module plab4_net_router_domain_sched #(
    parameter int unsigned p_num_domains = 2,
    parameter int unsigned p_slot_len    = 16,
    parameter int unsigned p_dead_len    = 3,
    localparam int unsigned c_sdw        = $clog2(p_num_domains),
    localparam int unsigned c_cntw       = $clog2(p_slot_len)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              drain_busy,
    input  logic              clr_err,
    output logic [c_sdw-1:0]  cur_sd,
    output logic              issue_ok,
    output logic [c_cntw-1:0] slot_cnt,
    output logic              epoch_start,
    output logic              leak_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    // Last slot index, and last index before the dead window begins
    localparam logic [c_cntw-1:0] c_cnt_last   = c_cntw'(p_slot_len - 1);
    localparam logic [c_cntw-1:0] c_cnt_act_end = c_cntw'(p_slot_len - p_dead_len - 1);
    localparam logic [c_sdw-1:0]  c_sd_last    = c_sdw'(p_num_domains - 1);

    state_t            state_q, state_d;
    logic [c_cntw-1:0] cnt_q, cnt_d;
    logic [c_sdw-1:0]  sd_q, sd_d;
    logic              issue_ok_q, issue_ok_d;
    logic              epoch_q, epoch_d;
    logic              leak_q, leak_d;
    logic              boundary_c;

    // Slot boundary: final cycle of the dead window
    assign boundary_c = (state_q == ST_DEAD) && (cnt_q == c_cnt_last);

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sd_q       <= '0;
            issue_ok_q <= 1'b0;
            epoch_q    <= 1'b0;
            leak_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sd_q       <= sd_d;
            issue_ok_q <= issue_ok_d;
            epoch_q    <= epoch_d;
            leak_q     <= leak_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sd_d    = sd_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                sd_d  = '0;
                if (en) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                cnt_d = cnt_q + c_cntw'(1);
                if (cnt_q == c_cnt_act_end) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (cnt_q == c_cnt_last) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = ST_ACTIVE;
                        sd_d    = (sd_q == c_sd_last) ? '0 : sd_q + c_sdw'(1);
                    end else begin
                        state_d = ST_IDLE;
                        sd_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q + c_cntw'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sd_d    = '0;
            end
        endcase

        // Registered decodes of the next state keep outputs free of input paths
        issue_ok_d = (state_d == ST_ACTIVE);
        epoch_d    = (state_d == ST_ACTIVE) && (cnt_d == '0) && (sd_d == '0);

        // Set dominates clear
        leak_d = (boundary_c && drain_busy) || (leak_q && !clr_err);
    end

    assign cur_sd      = sd_q;
    assign issue_ok    = issue_ok_q;
    assign slot_cnt    = cnt_q;
    assign epoch_start = epoch_q;
    assign leak_err    = leak_q;

endmodule

// File: tb/tb_plab4_net_router_domain_sched.sv
// Scoreboard bench for plab4_net_router_domain_sched: a default-parameter
// instance and a small corner instance (3 domains, 4-cycle slots, 1 dead cycle)
// share the same stimulus. A position-based model pushes expected outputs per
// clock edge; they are popped and compared one time unit after the edge.
module tb_plab4_net_router_domain_sched;

    localparam int S0 = 16;
    localparam int N0 = 2;
    localparam int D0 = 3;
    localparam int S1 = 4;
    localparam int N1 = 3;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       drain_busy;
    logic       clr_err;

    logic [0:0] sd0;
    logic [3:0] cnt0;
    logic       iok0, ep0, leak0;
    logic [1:0] sd1;
    logic [1:0] cnt1;
    logic       iok1, ep1, leak1;

    plab4_net_router_domain_sched u_dut0 (
        .clk(clk), .reset(reset), .en(en), .drain_busy(drain_busy), .clr_err(clr_err),
        .cur_sd(sd0), .issue_ok(iok0), .slot_cnt(cnt0), .epoch_start(ep0), .leak_err(leak0)
    );

    plab4_net_router_domain_sched #(
        .p_num_domains(N1), .p_slot_len(S1), .p_dead_len(D1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .drain_busy(drain_busy), .clr_err(clr_err),
        .cur_sd(sd1), .issue_ok(iok1), .slot_cnt(cnt1), .epoch_start(ep1), .leak_err(leak1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit run;
        int pos;
        bit leak;
    } mstate_t;

    typedef struct {
        int sd;
        int cnt;
        bit iok;
        bit ep;
        bit leak;
    } exp_t;

    mstate_t m0, m1;
    exp_t    q0[$];
    exp_t    q1[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      ep_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // Model: pos counts cycles since the run started; domain and slot index fall out of it
    function automatic mstate_t model_step(mstate_t s, int slen, bit e, bit d, bit c);
        mstate_t r;
        bit      bnd;
        r   = s;
        bnd = s.run && ((s.pos % slen) == slen - 1);
        r.leak = (bnd && d) ? 1'b1 : (c ? 1'b0 : s.leak);
        if (!s.run) begin
            if (e) begin
                r.run = 1'b1;
                r.pos = 0;
            end
        end else if (bnd && !e) begin
            r.run = 1'b0;
        end else begin
            r.pos = s.pos + 1;
        end
        return r;
    endfunction

    function automatic exp_t model_out(mstate_t s, int slen, int nd, int dl);
        exp_t e;
        e.sd   = s.run ? (s.pos / slen) % nd : 0;
        e.cnt  = s.run ? s.pos % slen : 0;
        e.iok  = s.run && (e.cnt < slen - dl);
        e.ep   = s.run && (e.cnt == 0) && (e.sd == 0);
        e.leak = s.leak;
        return e;
    endfunction

    task automatic compare(input string who, input exp_t e, input logic [31:0] sd,
                           input logic [31:0] cnt, input logic iok, input logic ep,
                           input logic leak);
        check_eq({who, ".cur_sd"},      sd,    32'(e.sd));
        check_eq({who, ".slot_cnt"},    cnt,   32'(e.cnt));
        check_eq({who, ".issue_ok"},    32'(iok),  32'(e.iok));
        check_eq({who, ".epoch_start"}, 32'(ep),   32'(e.ep));
        check_eq({who, ".leak_err"},    32'(leak), 32'(e.leak));
    endtask

    // One clock: model predicts at the edge, DUT is compared 1 time unit later
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        m0 = model_step(m0, S0, en, drain_busy, clr_err);
        q0.push_back(model_out(m0, S0, N0, D0));
        m1 = model_step(m1, S1, en, drain_busy, clr_err);
        q1.push_back(model_out(m1, S1, N1, D1));
        #1;
        e = q0.pop_front();
        compare("dflt", e, 32'(sd0), 32'(cnt0), iok0, ep0, leak0);
        e = q1.pop_front();
        compare("crnr", e, 32'(sd1), 32'(cnt1), iok1, ep1, leak1);
    endtask

    // Assert reset away from a clock edge; outputs must clear without a clock
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_eq({tag, ".sd0"},   32'(sd0),   0);
        check_eq({tag, ".cnt0"},  32'(cnt0),  0);
        check_eq({tag, ".iok0"},  32'(iok0),  0);
        check_eq({tag, ".ep0"},   32'(ep0),   0);
        check_eq({tag, ".leak0"}, 32'(leak0), 0);
        check_eq({tag, ".sd1"},   32'(sd1),   0);
        check_eq({tag, ".cnt1"},  32'(cnt1),  0);
        check_eq({tag, ".iok1"},  32'(iok1),  0);
        m0 = '{run: 1'b0, pos: 0, leak: 1'b0};
        m1 = '{run: 1'b0, pos: 0, leak: 1'b0};
    endtask

    function automatic int cnt_of0();
        return m0.run ? m0.pos % S0 : -1;
    endfunction

    initial begin
        en         = 1'b0;
        drain_busy = 1'b0;
        clr_err    = 1'b0;
        reset      = 1'b0;
        #2;
        do_reset("rst0");

        // Reset release with en=1, then a full epoch and beyond
        reset = 1'b1;
        en    = 1'b1;
        ep_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (ep0) ep_cnt++;
            if (i == 1)  check_eq("first.epoch", 32'(ep0), 1);
            if (i == 13) check_eq("cnt12.iok",   32'(iok0), 1);
            if (i == 14) check_eq("cnt13.iok",   32'(iok0), 0);
            if (i == 16) check_eq("cnt15.sd",    32'(sd0), 0);
            if (i == 17) check_eq("c17.sd",      32'(sd0), 1);
            if (i == 33) check_eq("c33.epoch",   32'(ep0), 1);
        end
        check_eq("epoch.count", 32'(ep_cnt), 2);

        // Drop en at slot_cnt=5 of domain 1: slot must complete, then idle
        for (int k = 0; k < 64 && !(model_out(m0, S0, N0, D0).sd == 1 && cnt_of0() == 5); k++)
            cycle();
        check_eq("reach.d1c5", 32'(cnt0), 5);
        en = 1'b0;
        for (int k = 0; k < 40 && m0.run; k++) cycle();
        check_eq("idle.reached", 32'(m0.run), 0);
        for (int k = 0; k < 3; k++) cycle();
        check_eq("idle.sd",  32'(sd0),  0);
        check_eq("idle.iok", 32'(iok0), 0);
        en = 1'b1;
        cycle();
        check_eq("restart.sd", 32'(sd0), 0);
        check_eq("restart.ep", 32'(ep0), 1);

        // Drain violation on a boundary cycle
        for (int k = 0; k < 40 && cnt_of0() != 15; k++) cycle();
        check_eq("reach.c15a", 32'(cnt0), 15);
        drain_busy = 1'b1;
        cycle();
        drain_busy = 1'b0;
        check_eq("leak.set", 32'(leak0), 1);
        for (int k = 0; k < 5; k++) cycle();
        check_eq("leak.held", 32'(leak0), 1);
        for (int k = 0; k < 40 && cnt_of0() != 15; k++) cycle();
        check_eq("reach.c15b", 32'(cnt0), 15);
        drain_busy = 1'b1;
        clr_err    = 1'b1;
        cycle();
        drain_busy = 1'b0;
        clr_err    = 1'b0;
        check_eq("leak.setwins", 32'(leak0), 1);
        cycle();
        cycle();
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check_eq("leak.clr", 32'(leak0), 0);

        // Asynchronous reset inside the dead window
        for (int k = 0; k < 40 && cnt_of0() != 14; k++) cycle();
        check_eq("reach.c14", 32'(cnt0), 14);
        do_reset("rst_dead");
        #2;
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i == 1)  check_eq("rr.first.cnt", 32'(cnt0), 0);
            if (i == 14) check_eq("rr.cnt13.iok", 32'(iok0), 0);
            if (i == 17) check_eq("rr.c17.sd",    32'(sd0), 1);
        end

        // Extra run for the corner instance (3 domains, 4-cycle slots)
        for (int k = 0; k < 12; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
